// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multi-digit BCD 7-segment display slice.
// Latency: none (package only).
// Backpressure: n/a.
//
// Contents: active-low segment patterns (bit6=a ... bit0=g), FSM state encoding,
// pow10() for sizing the display range, and the per-nibble add-3 step.
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        ~7'b1111110, ~7'b0110000, ~7'b1101101, ~7'b1111001, ~7'b0110011,
        ~7'b1011011, ~7'b1011111, ~7'b1110000, ~7'b1111111, ~7'b1110011
    };
    localparam logic [6:0] SEG_DASH  = ~7'b0000001;
    localparam logic [6:0] SEG_BLANK = ~7'b0000000;
    localparam logic [6:0] SEG_E     = ~7'b1001111;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the following doubling, so bias it by 3 to carry into the next digit.
    function automatic logic [3:0] add3_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_bcd_display_if.sv
// Input value handshake between the encoder logic and the display driver.
// Latency: n/a (wires only).
// Backpressure: source holds in_valid/in_data until in_ready; values offered while not ready are not queued.
//
// Signals: in_valid (source), in_data[DATA_W] (source), in_ready (display driver).
interface seg7_bcd_display_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seg7_bcd_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// Latency: DATA_W shift_i cycles after start_i; last_o flags the final shift cycle.
// Backpressure: none; the controller owns sequencing via start_i/shift_i.
//
// Ports: clk, reset (sync, high), start_i/bin_i load a value and clear the BCD
// register, shift_i advances one bit, last_o high during the DATA_W-th shift,
// bcd_o the 4*NUM_DIGITS-bit result (valid after that shift).
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    shift_i,
    input  logic [DATA_W-1:0]       bin_i,
    output logic                    last_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) adj[4*i +: 4] = add3_adj(bcd_q[4*i +: 4]);
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
        end else if (shift_i) begin
            // Corrected BCD and binary shift as one register; the BCD MSB drops
            // off when the value exceeds the display range (caught as overflow upstream).
            {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(DATA_W - 1));
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/seg7_bcd_display.sv
// Multi-digit active-low 7-segment driver: binary in, BCD by shift-add-3, per-digit encode.
// Latency: new value on seg_n DATA_W+1 edges after the accept edge; disp_en changes show one edge later.
// Backpressure: in_ready only while idle; in_valid during a conversion is ignored, not queued.
//
// Ports: clk, reset (sync, high); in_if (slave: in_valid, in_ready, in_data);
// disp_en (0 = dashes on every digit); busy (conversion in progress);
// seg_n[7*NUM_DIGITS] with digit i at [7*i+6:7*i], digit 0 rightmost.
// Build option: LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_bcd_display_if.slave       in_if,
    input  logic                    disp_en,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] seg_n
);
    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          SEG_W   = 7 * NUM_DIGITS;
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             disp_vld_q, disp_vld_d;   // a conversion has completed since reset
    logic             disp_ovf_q, disp_ovf_d;
    logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    logic             start, shift, latch, last;
    logic [BCD_W-1:0] bcd;
    logic [3:0]       nib;
    logic             nz;

    bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .shift_i (shift),
        .bin_i   (in_if.in_data),
        .last_o  (last),
        .bcd_o   (bcd)
    );

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        start   = 1'b0;
        shift   = 1'b0;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    start   = 1'b1;
                    ovf_d   = 64'(in_if.in_data) > MAX_VAL;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                latch   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    // The segment register is encoded from the display state it will hold
    // after this edge, so a completed result appears on the DONE edge itself.
    always_comb begin
        disp_vld_d = disp_vld_q | latch;
        disp_ovf_d = latch ? ovf_q : disp_ovf_q;
        disp_bcd_d = latch ? bcd : disp_bcd_q;
        seg_d      = '0;
        nib        = '0;
        nz         = 1'b0;
        // Walk from the most significant digit so nz means "some digit at or above i is non-zero".
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = disp_bcd_d[4*i +: 4];
            nz  = nz | (nib != 4'd0);
            if (!disp_en || !disp_vld_d)         seg_d[7*i +: 7] = SEG_DASH;
            else if (disp_ovf_d)                 seg_d[7*i +: 7] = SEG_E;
            else if (BLANK_EN && !nz && i != 0)  seg_d[7*i +: 7] = SEG_BLANK;
            else                                 seg_d[7*i +: 7] = seg_encode(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_vld_q <= 1'b0;
            disp_ovf_q <= 1'b0;
            disp_bcd_q <= '0;
            seg_q      <= {NUM_DIGITS{SEG_DASH}};
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            disp_vld_q <= disp_vld_d;
            disp_ovf_q <= disp_ovf_d;
            disp_bcd_q <= disp_bcd_d;
            seg_q      <= seg_d;
        end
    end

    assign in_if.in_ready = rdy_q;
    assign busy           = busy_q;
    assign seg_n          = seg_q;
endmodule

// File: tb/tb_seg7_bcd_display.sv
// Bench for seg7_bcd_display: a DATA_W=8 instance checked every cycle against a
// value-level model, plus a DATA_W=4 instance checked for exact latency.
// Both instances drive two digits.
module tb_seg7_bcd_display;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [13:0] DASH2 = {~7'b0000001, ~7'b0000001};
    localparam logic [6:0]  D1Z   = BLANK ? ~7'b0000000 : ~7'b1111110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rst8, en4, en8, busy4, busy8;
    logic [13:0] seg4, seg8;
    int          n_chk = 0;
    int          n_fail = 0;

    seg7_bcd_display_if #(.DATA_W(4)) if4 ();
    seg7_bcd_display_if #(.DATA_W(8)) if8 ();

    seg7_bcd_display #(.DATA_W(4), .NUM_DIGITS(2)) u4 (
        .clk(clk), .reset(rst4), .in_if(if4), .disp_en(en4), .busy(busy4), .seg_n(seg4));
    seg7_bcd_display #(.DATA_W(8), .NUM_DIGITS(2)) u8 (
        .clk(clk), .reset(rst8), .in_if(if8), .disp_en(en8), .busy(busy8), .seg_n(seg8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Active-low pattern for one decimal digit, from the a..g segment table.
    function automatic logic [6:0] pat(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'b1111110;  1: p = 7'b0110000;  2: p = 7'b1101101;
            3: p = 7'b1111001;  4: p = 7'b0110011;  5: p = 7'b1011011;
            6: p = 7'b1011111;  7: p = 7'b1110000;  8: p = 7'b1111111;
            default: p = 7'b1110011;
        endcase
        return ~p;
    endfunction

    function automatic logic [13:0] exp_seg(input int v, input bit has, input bit en);
        logic [6:0] hi, lo;
        if (!en || !has) return DASH2;
        if (v > 99) return {~7'b1001111, ~7'b1001111};
        lo = pat(v % 10);
        hi = (BLANK && v < 10) ? ~7'b0000000 : pat(v / 10);
        return {hi, lo};
    endfunction

    // Model of the DATA_W=8 instance: a conversion is a countdown of DATA_W+1
    // edges after acceptance; the display holds the last completed value.
    int m_cnt = 0, m_cap = 0, m_val = 0;
    bit m_has = 0, m_en = 0, m_live = 0;
    always @(posedge clk) begin
        if (rst8) begin
            m_cnt  = 0;
            m_has  = 0;
            m_live = 1;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_val = m_cap;
                m_has = 1;
            end
        end else if (if8.in_valid) begin
            m_cap = int'(if8.in_data);
            m_cnt = 9;
        end
        m_en = en8;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model seg_n", 32'(seg8), 32'(exp_seg(m_val, m_has, m_en)));
            chk("model in_ready", 32'(if8.in_ready), 32'(m_cnt == 0));
            chk("model busy", 32'(busy8), 32'(m_cnt != 0));
        end
    end

    task automatic load8(input int v);
        @(posedge clk); #1; if8.in_valid = 1'b1; if8.in_data = 8'(v);
        @(posedge clk); #1; if8.in_valid = 1'b0;
    endtask

    task automatic load4(input int v);
        @(posedge clk); #1; if4.in_valid = 1'b1; if4.in_data = 4'(v);
        @(posedge clk); #1; if4.in_valid = 1'b0;
    endtask

    task automatic wait_idle8();
        int k;
        k = 0;
        @(negedge clk);
        while (!if8.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("u8 ready within bound", 32'(if8.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          vals [6] = '{200, 99, 7, 0, 100, 10};
    logic [13:0] exps [6];

    initial begin
        int k;
        exps[0] = {~7'b1001111, ~7'b1001111};
        exps[1] = {~7'b1110011, ~7'b1110011};
        exps[2] = {D1Z, ~7'b1110000};
        exps[3] = {D1Z, ~7'b1111110};
        exps[4] = {~7'b1001111, ~7'b1001111};
        exps[5] = {~7'b0110000, ~7'b1111110};

        rst4 = 1'b1; rst8 = 1'b1; en4 = 1'b1; en8 = 1'b1;
        if4.in_valid = 1'b0; if4.in_data = '0;
        if8.in_valid = 1'b0; if8.in_data = '0;
        repeat (2) @(posedge clk);
        #1; rst4 = 1'b0; rst8 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset seg u4", 32'(seg4), 32'(DASH2));
        chk("reset ready u4", 32'(if4.in_ready), 32'd1);
        chk("reset busy u4", 32'(busy4), 32'd0);
        chk("reset seg u8", 32'(seg8), 32'(DASH2));

        // DATA_W=4: 13 appears exactly 5 edges after acceptance
        load4(13);
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e < 5) begin
                chk("u4 seg before done", 32'(seg4), 32'(DASH2));
                chk("u4 ready before done", 32'(if4.in_ready), 32'd0);
            end else begin
                chk("u4 seg 13", 32'(seg4), 32'({~7'b0110000, ~7'b1111001}));
                chk("u4 ready at done", 32'(if4.in_ready), 32'd1);
                chk("u4 busy at done", 32'(busy4), 32'd0);
            end
        end
        load4(15);
        k = 0;
        @(negedge clk);
        while (!if4.in_ready && k < 20) begin @(negedge clk); k++; end
        chk("u4 seg 15", 32'(seg4), 32'({~7'b0110000, ~7'b1011011}));

        // DATA_W=8 directed values incl. overflow boundary 99/100 and zero
        for (int i = 0; i < 6; i++) begin
            load8(vals[i]);
            wait_idle8();
            chk($sformatf("u8 seg for %0d", vals[i]), 32'(seg8), 32'(exps[i]));
        end

        // in_valid held during busy: 9 shows, then 3 is taken only afterwards
        @(posedge clk); #1; if8.in_valid = 1'b1; if8.in_data = 8'd9;
        @(posedge clk); #1; if8.in_data = 8'd3;
        wait_idle8();
        chk("u8 seg 09 with valid held", 32'(seg8), 32'({D1Z, ~7'b1110011}));
        @(posedge clk); #1; if8.in_valid = 1'b0;
        wait_idle8();
        chk("u8 seg 03 after held valid", 32'(seg8), 32'({D1Z, ~7'b1111001}));

        // disp_en dropped mid-conversion, restored after completion
        load8(9);
        @(posedge clk); #1; en8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("u8 dash while disabled", 32'(seg8), 32'(DASH2));
        wait_idle8();
        chk("u8 dash at done disabled", 32'(seg8), 32'(DASH2));
        @(posedge clk); #1; en8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("u8 seg 09 after enable", 32'(seg8), 32'({D1Z, ~7'b1110011}));

        // Reset two edges into converting 15: dashes, idle, never shows 15
        load8(15);
        @(posedge clk); #1; rst8 = 1'b1;
        @(posedge clk); #1; rst8 = 1'b0;
        @(negedge clk);
        chk("u8 dash after reset", 32'(seg8), 32'(DASH2));
        chk("u8 ready after reset", 32'(if8.in_ready), 32'd1);
        chk("u8 busy after reset", 32'(busy8), 32'd0);
        repeat (15) @(negedge clk);
        chk("u8 no stale 15", 32'(seg8), 32'(DASH2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
